// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, op encodings and memory-op decode helpers
package mem_access_pkg;
    localparam int ADDR_LEN     = 32;
    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int OP_LEN       = 5;
    localparam logic [REG_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic [OP_LEN-1:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_e;

    function automatic logic is_mem(input logic [OP_LEN-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store(input logic [OP_LEN-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // index of the last byte of the access (byte count minus one)
    function automatic logic [1:0] last_byte(input logic [OP_LEN-1:0] op);
        return (op == OP_LW || op == OP_SW) ? 2'd3 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/mem_access_load_ext.sv
// mem_access_load_ext: sign/zero extension of an assembled load buffer
module mem_access_load_ext
    import mem_access_pkg::*;
(
    input  logic [OP_LEN-1:0]  i_op,
    input  logic [REG_LEN-1:0] i_buf,
    output logic [REG_LEN-1:0] o_data
);
    always_comb
        o_data = (i_op == OP_LB)  ? {{24{i_buf[7]}}, i_buf[7:0]} :
                 (i_op == OP_LH)  ? {{16{i_buf[15]}}, i_buf[15:0]} :
                 (i_op == OP_LBU) ? {24'b0, i_buf[7:0]} :
                 (i_op == OP_LHU) ? {16'b0, i_buf[15:0]} : i_buf;
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage running loads/stores as sequential byte transfers
// and passing non-memory results straight to write-back.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    ex_valid,
    input  logic [OP_LEN-1:0]       op_i,
    input  logic [ADDR_LEN-1:0]     mem_addr_i,
    input  logic [REG_LEN-1:0]      rd_data_i,
    input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
    output logic                    mem_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_LEN-1:0]     mem_a,
    output logic [7:0]              mem_dout,
    input  logic [7:0]              mem_din,
    input  logic                    mem_ack,
    output logic                    wb_valid,
    output logic [REG_ADDR_LEN-1:0] wb_addr,
    output logic [REG_LEN-1:0]      wb_data
);
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACCESS = 1'b1;

    logic                    r_state, w_state_next;
    logic [OP_LEN-1:0]       r_op;
    logic [ADDR_LEN-1:0]     r_base;
    logic [REG_LEN-1:0]      r_data, r_buf, w_buf_next, w_ext;
    logic [REG_ADDR_LEN-1:0] r_rd;
    logic [1:0]              r_cnt, r_last;
    logic                    w_accept_mem, w_accept_alu, w_ack, w_done;

    assign w_accept_mem = r_state == S_IDLE && ex_valid && is_mem(op_i);
    assign w_accept_alu = r_state == S_IDLE && ex_valid && !is_mem(op_i);
    assign w_ack        = r_state == S_ACCESS && mem_ack;
    assign w_done       = w_ack && r_cnt == r_last;

    always_ff @(posedge clk)
        if (!rst) r_state <= S_IDLE;
        else if (rdy) r_state <= w_state_next;

    always_comb
        w_state_next = w_accept_mem ? S_ACCESS : w_done ? S_IDLE : r_state;

    always_comb begin
        mem_stall = r_state == S_ACCESS || w_accept_mem;
        mem_req   = r_state == S_ACCESS && rdy;
        mem_we    = r_state == S_ACCESS && is_store(r_op);
    end

    // address and write byte derive from registers only, so they move on ack edges
    assign mem_a    = r_base + {30'b0, r_cnt};
    assign mem_dout = r_data[{r_cnt, 3'b000} +: 8];

    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_cnt, 3'b000} +: 8] = mem_din;
    end

    mem_access_load_ext u_ext (
        .i_op   (r_op),
        .i_buf  (w_buf_next),
        .o_data (w_ext)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            r_op     <= '0;
            r_base   <= '0;
            r_data   <= ZERO_WORD;
            r_buf    <= ZERO_WORD;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_last   <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= ZERO_WORD;
        end else if (rdy) begin
            wb_valid <= 1'b0;
            if (w_accept_alu) begin
                wb_valid <= |rd_addr_i;
                wb_addr  <= rd_addr_i;
                wb_data  <= rd_data_i;
            end
            if (w_accept_mem) begin
                r_op   <= op_i;
                r_base <= mem_addr_i;
                r_data <= rd_data_i;
                r_rd   <= rd_addr_i;
                r_last <= last_byte(op_i);
                r_cnt  <= '0;
            end
            if (w_ack) begin
                r_buf <= w_buf_next;
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_done && !is_store(r_op)) begin
                wb_valid <= |r_rd;
                wb_addr  <= r_rd;
                wb_data  <= w_ext;
            end
        end
endmodule
